request_arbiter: RTL and testbench
==================================

# request_arbiter

Arbitrates between `NUM_PORTS` request-queue outputs (64-bit masked writes, valid/`wait_n` handshake) and one shared memory write port. Grants the port in bursts of up to `BURST_LEN` accepted transfers, rotating round-robin between requesters. Sits between the per-source request queues and the memory controller's write channel. All grant/burst state is registered; the data path from the granted port to the output is combinational.

## Interface
Parameters:
- `NUM_PORTS`, 3: number of requesters (2..8).
- `BURST_LEN`, 8: maximum accepted transfers per grant (≥1).
- `ADDR_WIDTH`, 32: address width.

Ports:
- `clock`  in  1  single clock; all logic is on its rising edge.
- `reset_n`  in  1  synchronous reset, active-low.
- `io_enable`  in  1  permits new grants; a burst in progress always completes.
- `io_in_wr`  in  NUM_PORTS  per-port write request.
- `io_in_addr`  in  NUM_PORTS*ADDR_WIDTH  per-port byte address; port i occupies slice i.
- `io_in_mask`  in  NUM_PORTS*8  per-port byte mask.
- `io_in_din`  in  NUM_PORTS*64  per-port write data.
- `io_in_wait_n`  out  NUM_PORTS  per-port accept; high means the port's request is taken this cycle.
- `io_out_wr`  out  1  memory write request.
- `io_out_addr`  out  ADDR_WIDTH  memory address.
- `io_out_mask`  out  8  memory byte mask.
- `io_out_din`  out  64  memory write data.
- `io_out_wait_n`  in  1  memory accept.
- `io_grant`  out  NUM_PORTS  one-hot current grant; 0 in IDLE.

## Operation
- Transfer definition:
  - Upstream transfer on port i: `io_in_wr[i] & io_in_wait_n[i]`.
  - Downstream transfer: `io_out_wr & io_out_wait_n`.
- State: FSM {IDLE, BUSY}, grant index `g`, round-robin pointer `ptr` (last granted index), burst counter `cnt` of width clog2(BURST_LEN), minimum 1.
- IDLE:
  - `io_out_wr`=0, all `io_in_wait_n`=0, `io_grant`=0. `io_out_addr`, `io_out_mask`, `io_out_din` are 0.
  - If `io_enable`=1 and any `io_in_wr` is high, select the first requesting port scanning ptr+1, ptr+2, … modulo NUM_PORTS.
  - Next state: BUSY, `g`=selected port, `cnt`=0.
- BUSY:
  - `io_out_*` = port g's `wr`/`addr`/`mask`/`din`.
  - `io_in_wait_n[g]` = `io_out_wait_n`; every other `io_in_wait_n` = 0.
  - Each downstream transfer increments `cnt`.
- BUSY exit to IDLE, with `ptr`=g, when either:
  - a transfer occurs with `cnt`==BURST_LEN-1, or
  - `io_in_wr[g]`=0 in a cycle (no transfer that cycle).
- Ordering: per-port request order is preserved. No request is ever duplicated or dropped.
- Fairness: a continuously requesting port waits at most (NUM_PORTS-1) bursts.

## Timing
- Reset (`reset_n` low at an edge): IDLE, `ptr`=NUM_PORTS-1 (port 0 wins first), `cnt`=0, `g`=0. All outputs read 0 from that edge, including mid-burst; the interrupted burst is abandoned.
- Arbitration latency: a request seen in IDLE is granted 1 cycle later; the earliest downstream transfer is the cycle after the request is first seen.
- A release always passes through one IDLE cycle, so there is exactly 1 bubble cycle between consecutive grants.
- Combinational paths: `io_out_wait_n`→`io_in_wait_n[g]`, and port g inputs→`io_out_*`. No combinational path from any input to `io_grant`.
- `io_enable` low in BUSY: the burst continues. `io_enable` low in IDLE: no grant.
- A port raising `io_in_wr` during another port's burst waits for that burst to release.
- The `io_out_*` signals are stable while `io_out_wr`=1 and `io_out_wait_n`=0, provided the granted source holds its request.

## Configuration
- `REQUEST_ARBITER_FIXED_PRIORITY_EN`:
  - Defined: IDLE selection is fixed priority, with the lowest index winning. `ptr` is unused.
  - Undefined (default): round-robin as above.

## Test plan
- Reset → `io_out_wr`=0, `io_in_wait_n`=0, `io_grant`=0. Assert `io_in_wr[0]` with `io_out_wait_n`=1 → `io_grant`=3'b001 the next cycle and a transfer that cycle.
- Ports 0 and 2 request continuously, BURST_LEN=8, `io_out_wait_n`=1 → 8 transfers from port 0, 1 bubble, 8 from port 2, 1 bubble, 8 from port 0.
- Port 1 bursts while `io_out_wait_n` toggles 1,0,1,0… → exactly 8 transfers, addresses in order, `io_in_wait_n[1]` equals `io_out_wait_n`, stalled outputs stable.
- Port 1 drops `io_in_wr` after 3 transfers while port 0 requests → release, 1 IDLE cycle, then port 0 granted (not port 1).
- `reset_n` low on the 4th transfer of a burst → all outputs 0 from that edge. After release, port 0 is granted first.
- With the fixed-priority macro, ports 0 and 1 request continuously → port 0 is granted on every arbitration and port 1 never is.

Source files
------------

// File: rtl/request_arbiter_if.sv
// request_arbiter_if: bundle of request-side and memory-side signals for request_arbiter.
//
// Signals (arbiter view):
//   io_enable      in   permits new grants
//   io_in_wr       in   per-port write request
//   io_in_addr     in   per-port address, port i at slice i
//   io_in_mask     in   per-port byte mask, port i at slice i
//   io_in_din      in   per-port write data, port i at slice i
//   io_in_wait_n   out  per-port accept
//   io_out_wr      out  memory write request
//   io_out_addr    out  memory address
//   io_out_mask    out  memory byte mask
//   io_out_din     out  memory write data
//   io_out_wait_n  in   memory accept
//   io_grant       out  one-hot current grant
//
// modport master: the arbiter.  modport slave: request queues plus memory controller.
interface request_arbiter_if #(
    parameter int unsigned NUM_PORTS  = 3,
    parameter int unsigned ADDR_WIDTH = 32
);
    logic                            io_enable;
    logic [NUM_PORTS-1:0]            io_in_wr;
    logic [NUM_PORTS*ADDR_WIDTH-1:0] io_in_addr;
    logic [NUM_PORTS*8-1:0]          io_in_mask;
    logic [NUM_PORTS*64-1:0]         io_in_din;
    logic [NUM_PORTS-1:0]            io_in_wait_n;
    logic                            io_out_wr;
    logic [ADDR_WIDTH-1:0]           io_out_addr;
    logic [7:0]                      io_out_mask;
    logic [63:0]                     io_out_din;
    logic                            io_out_wait_n;
    logic [NUM_PORTS-1:0]            io_grant;

    modport master (
        input  io_enable,
        input  io_in_wr,
        input  io_in_addr,
        input  io_in_mask,
        input  io_in_din,
        output io_in_wait_n,
        output io_out_wr,
        output io_out_addr,
        output io_out_mask,
        output io_out_din,
        input  io_out_wait_n,
        output io_grant
    );

    modport slave (
        output io_enable,
        output io_in_wr,
        output io_in_addr,
        output io_in_mask,
        output io_in_din,
        input  io_in_wait_n,
        input  io_out_wr,
        input  io_out_addr,
        input  io_out_mask,
        input  io_out_din,
        output io_out_wait_n,
        input  io_grant
    );
endinterface

// File: rtl/request_arbiter.sv
// request_arbiter: grants one of NUM_PORTS masked-write request queues access to a shared
// memory write port, in bursts of up to BURST_LEN accepted transfers, round-robin between
// requesters. Grant/burst state is registered; the granted port's data path is combinational.
//
// Ports:
//   clock    in  rising-edge clock
//   reset_n  in  synchronous active-low reset
//   bus      request_arbiter_if.master (request ports, memory port, grant)
//
// Build option:
//   REQUEST_ARBITER_FIXED_PRIORITY_EN  defined: lowest requesting index wins each arbitration
//                                      undefined (default): round-robin after last grant
module request_arbiter #(
    parameter int unsigned NUM_PORTS  = 3,
    parameter int unsigned BURST_LEN  = 8,
    parameter int unsigned ADDR_WIDTH = 32
) (
    input logic               clock,
    input logic               reset_n,
    request_arbiter_if.master bus
);
    localparam int unsigned GW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int unsigned CW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [CW-1:0] CntLast = CW'(BURST_LEN - 1);
    localparam logic [NUM_PORTS-1:0] OneHot0 = {{(NUM_PORTS-1){1'b0}}, 1'b1};

    typedef enum logic [0:0] {StIdle, StBusy} state_e;

    state_e               state_q;
    logic [GW-1:0]        g_q;
    logic [GW-1:0]        ptr_q;
    logic [CW-1:0]        cnt_q;
    logic [NUM_PORTS-1:0] grant_q;

    logic                 sel_found;
    logic [GW-1:0]        sel_idx;
    int unsigned          g_int;

    assign g_int = 32'(g_q);

    // Arbitration choice among current requesters; only consumed in IDLE.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
`ifdef REQUEST_ARBITER_FIXED_PRIORITY_EN
        // Scan from the top so the lowest requesting index is the last one written.
        for (int i = int'(NUM_PORTS) - 1; i >= 0; i--) begin
            if (bus.io_in_wr[i]) begin
                sel_found = 1'b1;
                sel_idx   = GW'(i);
            end
        end
`else
        // Scan ptr+NUM_PORTS down to ptr+1 so ptr+1 (nearest after last grant) wins.
        for (int k = int'(NUM_PORTS); k >= 1; k--) begin
            int idx;
            idx = (int'(ptr_q) + k) % int'(NUM_PORTS);
            if (bus.io_in_wr[idx]) begin
                sel_found = 1'b1;
                sel_idx   = GW'(idx);
            end
        end
`endif
    end

    // Steering: port g drives the memory port; memory accept goes back to port g only.
    always_comb begin
        bus.io_out_wr    = 1'b0;
        bus.io_out_addr  = '0;
        bus.io_out_mask  = '0;
        bus.io_out_din   = '0;
        bus.io_in_wait_n = '0;
        if (state_q == StBusy) begin
            bus.io_out_wr           = bus.io_in_wr[g_q];
            bus.io_out_addr         = bus.io_in_addr[g_int*ADDR_WIDTH +: ADDR_WIDTH];
            bus.io_out_mask         = bus.io_in_mask[g_int*8 +: 8];
            bus.io_out_din          = bus.io_in_din[g_int*64 +: 64];
            bus.io_in_wait_n[g_q]   = bus.io_out_wait_n;
        end
    end

    assign bus.io_grant = grant_q;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q <= StIdle;
            g_q     <= '0;
            ptr_q   <= GW'(NUM_PORTS - 1);
            cnt_q   <= '0;
            grant_q <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.io_enable && sel_found) begin
                        state_q <= StBusy;
                        g_q     <= sel_idx;
                        cnt_q   <= '0;
                        grant_q <= OneHot0 << sel_idx;
                    end
                end
                StBusy: begin
                    if (!bus.io_in_wr[g_q]) begin
                        // Source went quiet: give the port up rather than wait on it.
                        state_q <= StIdle;
                        ptr_q   <= g_q;
                        cnt_q   <= '0;
                        grant_q <= '0;
                    end else if (bus.io_out_wait_n) begin
                        if (cnt_q == CntLast) begin
                            state_q <= StIdle;
                            ptr_q   <= g_q;
                            cnt_q   <= '0;
                            grant_q <= '0;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= StIdle;
                    grant_q <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_request_arbiter.sv
// Self-checking bench for request_arbiter: per-port request queues feed the DUT, each issued
// request is pushed into a per-port expected queue, and a negedge monitor pops and compares on
// every downstream transfer while a cycle-level arbitration model predicts the grant.
module tb_request_arbiter;
    localparam int NP = 3;
    localparam int BL = 8;
    localparam int AW = 32;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [7:0]    mask;
        logic [63:0]   din;
    } req_t;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    request_arbiter_if #(.NUM_PORTS(NP), .ADDR_WIDTH(AW)) bus ();

    request_arbiter #(
        .NUM_PORTS (NP),
        .BURST_LEN (BL),
        .ADDR_WIDTH(AW)
    ) dut (
        .clock  (clock),
        .reset_n(reset_n),
        .bus    (bus)
    );

    int n_vec = 0;
    int n_mis = 0;

    req_t src_q[NP][$];
    req_t exp_q[NP][$];
    int   seq[NP];

    logic [NP-1:0] active    = '0;
    int            drop_pct  = 0;
    int            wait_mode = 0;
    int            en_pct    = 100;
    logic [NP-1:0] acc       = '0;
    int            cyc       = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        n_vec++;
        if (act !== req) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic add_reqs(input int p, input int n);
        req_t r;
        for (int i = 0; i < n; i++) begin
            r.addr = AW'((p << 24) + seq[p] * 8);
            r.mask = 8'($urandom);
            r.din  = {$urandom, $urandom};
            seq[p]++;
            src_q[p].push_back(r);
            exp_q[p].push_back(r);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic reset_dut();
        active = '0;
        repeat (3) tick();
        reset_n = 1'b0;
        tick();
        tick();
        for (int p = 0; p < NP; p++) begin
            src_q[p].delete();
            exp_q[p].delete();
        end
        reset_n = 1'b1;
    endtask

    function automatic int oh_idx(input logic [NP-1:0] v);
        int r;
        r = 0;
        for (int i = 0; i < NP; i++) if (v[i]) r = i;
        return r;
    endfunction

    // Source and memory-side driver: inputs change 1 time unit after the rising edge.
    initial begin
        bus.io_in_wr      = '0;
        bus.io_in_addr    = '0;
        bus.io_in_mask    = '0;
        bus.io_in_din     = '0;
        bus.io_enable     = 1'b1;
        bus.io_out_wait_n = 1'b1;
        forever begin
            @(posedge clock);
            #1;
            cyc++;
            for (int p = 0; p < NP; p++) begin
                if (acc[p] && src_q[p].size() > 0) void'(src_q[p].pop_front());
                if (active[p] && src_q[p].size() > 0 && $urandom_range(99) >= drop_pct) begin
                    bus.io_in_wr[p]            = 1'b1;
                    bus.io_in_addr[p*AW +: AW] = src_q[p][0].addr;
                    bus.io_in_mask[p*8 +: 8]   = src_q[p][0].mask;
                    bus.io_in_din[p*64 +: 64]  = src_q[p][0].din;
                end else begin
                    bus.io_in_wr[p]            = 1'b0;
                    bus.io_in_addr[p*AW +: AW] = AW'($urandom);
                    bus.io_in_mask[p*8 +: 8]   = 8'($urandom);
                    bus.io_in_din[p*64 +: 64]  = {$urandom, $urandom};
                end
            end
            case (wait_mode)
                0:       bus.io_out_wait_n = 1'b1;
                1:       bus.io_out_wait_n = cyc[0];
                default: bus.io_out_wait_n = 1'($urandom_range(1));
            endcase
            bus.io_enable = ($urandom_range(99) < en_pct);
        end
    end

    // Reference model state: values seen at the previous falling edge.
    logic          p_rst   = 1'b0;
    logic          p_en    = 1'b0;
    logic [NP-1:0] p_wr    = '0;
    logic          p_xfer  = 1'b0;
    logic          p_stall = 1'b0;
    logic [NP-1:0] p_eg    = '0;
    logic [103:0]  p_bus   = '0;
    logic [NP-1:0] m_grant = '0;
    int            mptr    = NP - 1;
    int            mcnt    = 0;

    always @(negedge clock) begin
        logic [NP-1:0] eg;
        logic [103:0]  cur_bus;
        int            g;
        int            pick;
        req_t          r;

        eg = m_grant;
        if (!p_rst) begin
            eg   = '0;
            mptr = NP - 1;
            mcnt = 0;
        end else if (m_grant == '0) begin
            if (p_en && p_wr != '0) begin
                pick = -1;
`ifdef REQUEST_ARBITER_FIXED_PRIORITY_EN
                for (int i = 0; i < NP; i++) if (pick < 0 && p_wr[i]) pick = i;
`else
                for (int k = 1; k <= NP; k++) begin
                    int idx;
                    idx = (mptr + k) % NP;
                    if (pick < 0 && p_wr[idx]) pick = idx;
                end
`endif
                eg   = NP'(1) << pick;
                mcnt = 0;
            end
        end else begin
            g = oh_idx(m_grant);
            if (!p_wr[g]) begin
                eg   = '0;
                mptr = g;
            end else if (p_xfer) begin
                mcnt++;
                if (mcnt == BL) begin
                    eg   = '0;
                    mptr = g;
                    mcnt = 0;
                end
            end
        end
        m_grant = eg;

        check("grant", bus.io_grant, eg);
        cur_bus = {bus.io_out_addr, bus.io_out_mask, bus.io_out_din};
        g = oh_idx(eg);
        if (eg == '0) begin
            check("idle_ctl", {bus.io_out_wr, bus.io_in_wait_n}, '0);
            check("idle_data", cur_bus, '0);
        end else begin
            check("out_wr", bus.io_out_wr, bus.io_in_wr[g]);
            check("in_wait_n", bus.io_in_wait_n, bus.io_out_wait_n ? eg : '0);
            check("out_bus", cur_bus, {bus.io_in_addr[g*AW +: AW], bus.io_in_mask[g*8 +: 8],
                                       bus.io_in_din[g*64 +: 64]});
            if (p_stall && p_eg == eg && bus.io_in_wr[g]) check("stall_stable", cur_bus, p_bus);
            if (bus.io_in_wr[g] && bus.io_out_wait_n) begin
                if (exp_q[g].size() == 0) begin
                    check("unexpected_xfer", 1'b1, 1'b0);
                end else begin
                    r = exp_q[g].pop_front();
                    check("xfer_data", cur_bus, r);
                end
            end
        end

        acc     = bus.io_in_wr & bus.io_in_wait_n;
        p_rst   = reset_n;
        p_en    = bus.io_enable;
        p_wr    = bus.io_in_wr;
        p_xfer  = (eg != '0) && bus.io_in_wr[g] && bus.io_out_wait_n;
        p_stall = (eg != '0) && bus.io_in_wr[g] && !bus.io_out_wait_n;
        p_eg    = eg;
        p_bus   = cur_bus;
    end

    logic [NP-1:0] pat_exp;
    int            n;
    int            k;
    logic          saw1;

    initial begin
        for (int p = 0; p < NP; p++) seq[p] = 0;

        // Reset values and first-grant latency.
        repeat (2) tick();
        @(negedge clock);
        check("rst_grant", bus.io_grant, '0);
        check("rst_ctl", {bus.io_out_wr, bus.io_in_wait_n}, '0);
        reset_dut();
        add_reqs(0, 4);
        active = 3'b001;
        @(negedge clock);
        @(negedge clock);
        check("lat_idle", bus.io_grant, 3'b000);
        @(negedge clock);
        check("lat_grant", bus.io_grant, 3'b001);
        check("lat_xfer", {bus.io_out_wr, bus.io_in_wait_n}, 4'b1001);

        // Ports 0 and 2 continuous: 8 / bubble / 8 / bubble / 8.
        reset_dut();
        add_reqs(0, 30);
        add_reqs(2, 30);
        active = 3'b101;
        k = 0;
        @(negedge clock);
        while (bus.io_grant == '0 && k < 20) begin
            @(negedge clock);
            k++;
        end
        for (int i = 0; i < 26; i++) begin
            pat_exp = (i < 8) ? 3'b001 : (i == 8) ? 3'b000 : (i < 17) ? 3'b100 :
                      (i == 17) ? 3'b000 : 3'b001;
            check("rr_pattern", bus.io_grant, pat_exp);
            @(negedge clock);
        end

        // Port 1 burst against a toggling memory accept.
        reset_dut();
        add_reqs(1, 20);
        wait_mode = 1;
        active    = 3'b010;
        k = 0;
        @(negedge clock);
        while (bus.io_grant != 3'b010 && k < 50) begin
            @(negedge clock);
            k++;
        end
        check("tog_grant", bus.io_grant, 3'b010);
        n = 0;
        k = 0;
        while (bus.io_grant == 3'b010 && k < 40) begin
            if (bus.io_out_wr && bus.io_out_wait_n) n++;
            check("tog_wait_n", bus.io_in_wait_n[1], bus.io_out_wait_n);
            @(negedge clock);
            k++;
        end
        check("tog_count", n, BL);
        wait_mode = 0;

        // Port 1 runs dry after 3 transfers while port 0 waits.
        reset_dut();
        add_reqs(1, 3);
        add_reqs(0, 20);
        active = 3'b010;
        k = 0;
        @(negedge clock);
        while (bus.io_grant != 3'b010 && k < 50) begin
            @(negedge clock);
            k++;
        end
        tick();
        active = 3'b011;
        k = 0;
        @(negedge clock);
        while (bus.io_grant == 3'b010 && k < 50) begin
            @(negedge clock);
            k++;
        end
        check("drop_bubble", bus.io_grant, 3'b000);
        @(negedge clock);
        check("drop_next", bus.io_grant, 3'b001);

        // Reset on the 4th transfer of a burst.
        reset_dut();
        add_reqs(0, 20);
        add_reqs(1, 10);
        active = 3'b001;
        n = 0;
        k = 0;
        while (n < 3 && k < 60) begin
            @(negedge clock);
            if (bus.io_out_wr && bus.io_out_wait_n) n++;
            k++;
        end
        tick();
        reset_n = 1'b0;
        @(negedge clock);
        check("mid_xfer4", bus.io_out_wr & bus.io_out_wait_n, 1'b1);
        @(negedge clock);
        check("mid_rst_grant", bus.io_grant, '0);
        check("mid_rst_ctl", {bus.io_out_wr, bus.io_in_wait_n}, '0);
        tick();
        tick();
        reset_n = 1'b1;
        active  = 3'b011;
        k = 0;
        @(negedge clock);
        while (bus.io_grant == '0 && k < 20) begin
            @(negedge clock);
            k++;
        end
        check("post_rst_grant", bus.io_grant, 3'b001);

        // Ports 0 and 1 continuous: fixed priority starves port 1, round-robin does not.
        reset_dut();
        add_reqs(0, 40);
        add_reqs(1, 40);
        active = 3'b011;
        saw1 = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (bus.io_grant == 3'b010) saw1 = 1'b1;
        end
`ifdef REQUEST_ARBITER_FIXED_PRIORITY_EN
        check("fixed_no_port1", saw1, 1'b0);
`else
        check("rr_port1_served", saw1, 1'b1);
`endif

        // Randomised traffic on all ports.
        reset_dut();
        for (int p = 0; p < NP; p++) add_reqs(p, 40);
        drop_pct  = 20;
        wait_mode = 2;
        en_pct    = 85;
        active    = 3'b111;
        k = 0;
        while (k < 3000 && (src_q[0].size() + src_q[1].size() + src_q[2].size()) != 0) begin
            @(negedge clock);
            k++;
        end
        active = '0;
        repeat (4) @(negedge clock);
        for (int p = 0; p < NP; p++) check("drained", 32'(exp_q[p].size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end
endmodule
